// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu - load/store unit for the jedro_1 core.
//
// Takes one load or store request at a time from the decode stage, turns it
// into a single word-aligned bus transaction with byte enables, and for
// loads extracts, sign/zero-extends and writes back the addressed lanes.
// Misaligned or illegal-size requests are rejected without touching the bus.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   ctrl_*              request handshake and fields (we, size, unsigned,
//                       addr, wdata, rd); ctrl_ready_o is high while idle
//   mem_req_o/gnt_i     bus request/grant
//   mem_addr_o/we_o/    word address, write enable, byte enables,
//   be_o/wdata_o        lane-replicated write data
//   mem_rvalid_i/rdata_i read response
//   wb_addr_o/data_o/   register file write port (one-cycle wb_we_o pulse)
//   we_o
//   misaligned_o        one-cycle pulse when a request is rejected
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ctrl_valid_i,
    output logic                      ctrl_ready_o,
    input  logic                      ctrl_we_i,
    input  logic [1:0]                ctrl_size_i,
    input  logic                      ctrl_unsigned_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      wb_we_o,
    output logic                      misaligned_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic                      accept;
    logic                      misaligned;
    logic [3:0]                be_new;
    logic [DATA_WIDTH-1:0]     wdata_new;

    logic                      we_q;
    logic                      unsigned_q;
    logic [1:0]                size_q;
    logic [1:0]                offset_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    logic [DATA_WIDTH-1:0]     rdata_shifted;
    logic [DATA_WIDTH-1:0]     load_data;

    assign accept = ctrl_valid_i && (state == IDLE);

    // Alignment check and lane placement for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b0000;
        wdata_new  = ctrl_wdata_i;
        case (ctrl_size_i)
            2'b00: begin
                be_new    = 4'b0001 << ctrl_addr_i[1:0];
                wdata_new = {4{ctrl_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = ctrl_addr_i[0];
                be_new     = 4'b0011 << ctrl_addr_i[1:0];
                wdata_new  = {2{ctrl_wdata_i[15:0]}};
            end
            2'b10: begin
                misaligned = (ctrl_addr_i[1:0] != 2'b00);
                be_new     = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; grant only matters in REQ, rvalid only in RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !misaligned) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_next = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ctrl_ready_o = (state == IDLE);
        mem_req_o    = (state == REQ);
        mem_we_o     = (state == REQ) && we_q;
    end

    // Request fields are captured only for aligned accepts, so the bus
    // outputs stay stable from acceptance through the grant cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            offset_q     <= 2'b00;
            rd_q         <= '0;
            mem_addr_o   <= '0;
            mem_be_o     <= 4'b0000;
            mem_wdata_o  <= '0;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= accept && misaligned;
            if (accept && !misaligned) begin
                we_q        <= ctrl_we_i;
                unsigned_q  <= ctrl_unsigned_i;
                size_q      <= ctrl_size_i;
                offset_q    <= ctrl_addr_i[1:0];
                rd_q        <= ctrl_rd_i;
                mem_addr_o  <= {ctrl_addr_i[DATA_WIDTH-1:2], 2'b00};
                mem_be_o    <= be_new;
                mem_wdata_o <= wdata_new;
            end
        end
    end

    // Move the addressed lanes down to bit 0, then truncate and extend.
    always_comb begin
        rdata_shifted = mem_rdata_i >> {offset_q, 3'b000};
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'h000000, rdata_shifted[7:0]}
                                            : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_data = unsigned_q ? {16'h0000, rdata_shifted[15:0]}
                                            : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // Writeback pulse; x0 is never written, and the address/data registers
    // only change when a real write happens.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
        end else begin
            wb_we_o <= 1'b0;
            if ((state == RESP) && mem_rvalid_i && (rd_q != '0)) begin
                wb_we_o   <= 1'b1;
                wb_addr_o <= rd_q;
                wb_data_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb_jedro_1_lsu - directed self-checking bench for jedro_1_lsu.
//
// Inputs are driven and outputs sampled 1ns after each rising edge, so a
// check right after cyc() sees the state produced by that edge.
module tb_jedro_1_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ctrl_valid_i = 1'b0;
    logic        ctrl_ready_o;
    logic        ctrl_we_i = 1'b0;
    logic [1:0]  ctrl_size_i = 2'b00;
    logic        ctrl_unsigned_i = 1'b0;
    logic [31:0] ctrl_addr_i = '0;
    logic [31:0] ctrl_wdata_i = '0;
    logic [4:0]  ctrl_rd_i = '0;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic        misaligned_o;

    int nAsserts = 0;
    int nFail    = 0;

    jedro_1_lsu #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ctrl_valid_i    (ctrl_valid_i),
        .ctrl_ready_o    (ctrl_ready_o),
        .ctrl_we_i       (ctrl_we_i),
        .ctrl_size_i     (ctrl_size_i),
        .ctrl_unsigned_i (ctrl_unsigned_i),
        .ctrl_addr_i     (ctrl_addr_i),
        .ctrl_wdata_i    (ctrl_wdata_i),
        .ctrl_rd_i       (ctrl_rd_i),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .wb_addr_o       (wb_addr_o),
        .wb_data_o       (wb_data_o),
        .wb_we_o         (wb_we_o),
        .misaligned_o    (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // One comparison point: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the request fields.
    task automatic applyStimulus(input logic valid, input logic we,
                                 input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd);
        ctrl_valid_i    = valid;
        ctrl_we_i       = we;
        ctrl_size_i     = size;
        ctrl_unsigned_i = uns;
        ctrl_addr_i     = addr;
        ctrl_wdata_i    = wdata;
        ctrl_rd_i       = rd;
    endtask

    // Minimum-latency load: accept N, grant N+1, rvalid N+2; returns at N+3.
    task automatic runLoad(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [31:0] expAddr,
                           input logic [3:0] expBe);
        applyStimulus(1'b1, 1'b0, size, uns, addr, 32'h0, rd);
        checkOutput({tag, "_ready"}, ctrl_ready_o, 1);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput({tag, "_req"}, mem_req_o, 1);
        checkOutput({tag, "_addr"}, mem_addr_o, expAddr);
        checkOutput({tag, "_be"}, mem_be_o, expBe);
        checkOutput({tag, "_we"}, mem_we_o, 0);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        checkOutput({tag, "_req_drop"}, mem_req_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        cyc();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        // Reset values.
        cyc();
        cyc();
        checkOutput("rst_req", mem_req_o, 0);
        checkOutput("rst_wb_we", wb_we_o, 0);
        checkOutput("rst_mis", misaligned_o, 0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_be", mem_be_o, 4'h0);
        checkOutput("rst_wb_data", wb_data_o, 32'h0);
        rst_i = 1'b0;
        cyc();
        checkOutput("rst_ready", ctrl_ready_o, 1);

        // Load word 0x100 -> x5.
        runLoad("lw", 2'b10, 1'b0, 32'h100, 5'd5, 32'hDEADBEEF, 32'h100, 4'b1111);
        checkOutput("lw_wb_we", wb_we_o, 1);
        checkOutput("lw_wb_addr", wb_addr_o, 5);
        checkOutput("lw_wb_data", wb_data_o, 32'hDEADBEEF);
        checkOutput("lw_ready_again", ctrl_ready_o, 1);
        cyc();
        checkOutput("lw_wb_pulse_end", wb_we_o, 0);
        checkOutput("lw_wb_data_hold", wb_data_o, 32'hDEADBEEF);

        // Byte loads from the top lane, signed then unsigned.
        runLoad("lb", 2'b00, 1'b0, 32'h103, 5'd7, 32'h80FF0000, 32'h100, 4'b1000);
        checkOutput("lb_wb_we", wb_we_o, 1);
        checkOutput("lb_wb_addr", wb_addr_o, 7);
        checkOutput("lb_wb_data", wb_data_o, 32'hFFFFFF80);
        cyc();
        runLoad("lbu", 2'b00, 1'b1, 32'h103, 5'd7, 32'h80FF0000, 32'h100, 4'b1000);
        checkOutput("lbu_wb_data", wb_data_o, 32'h00000080);
        cyc();

        // Signed half at 0x102 with a delayed grant; rvalid during REQ is ignored.
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55555555;
        cyc();
        mem_rvalid_i = 1'b0;
        checkOutput("lh_req_wait", mem_req_o, 1);
        checkOutput("lh_be", mem_be_o, 4'b1100);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        checkOutput("lh_req_drop", mem_req_o, 0);
        checkOutput("lh_no_early_wb", wb_we_o, 0);
        cyc();
        checkOutput("lh_resp_wait", ctrl_ready_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBEEF1234;
        cyc();
        mem_rvalid_i = 1'b0;
        checkOutput("lh_wb_we", wb_we_o, 1);
        checkOutput("lh_wb_addr", wb_addr_o, 9);
        checkOutput("lh_wb_data", wb_data_o, 32'hFFFFBEEF);
        cyc();

        // Store half 0x202 with grant held low for three cycles.
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd0);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("sh_req", mem_req_o, 1);
            checkOutput("sh_addr", mem_addr_o, 32'h200);
            checkOutput("sh_be", mem_be_o, 4'b1100);
            checkOutput("sh_wdata", mem_wdata_o, 32'hABCDABCD);
            checkOutput("sh_we", mem_we_o, 1);
            if (i == 3) begin
                mem_gnt_i = 1'b1;
            end
            cyc();
        end
        mem_gnt_i = 1'b0;
        checkOutput("sh_req_drop", mem_req_o, 0);
        checkOutput("sh_ready", ctrl_ready_o, 1);
        checkOutput("sh_no_wb", wb_we_o, 0);

        // Store byte 0x101 and store word 0x300.
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 5'd0);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput("sb_be", mem_be_o, 4'b0010);
        checkOutput("sb_wdata", mem_wdata_o, 32'h5A5A5A5A);
        checkOutput("sb_addr", mem_addr_o, 32'h100);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        checkOutput("sb_ready", ctrl_ready_o, 1);
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput("sw_be", mem_be_o, 4'b1111);
        checkOutput("sw_wdata", mem_wdata_o, 32'hCAFEF00D);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;

        // Misaligned word load and illegal size.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput("mis_pulse", misaligned_o, 1);
        checkOutput("mis_no_req", mem_req_o, 0);
        checkOutput("mis_ready", ctrl_ready_o, 1);
        cyc();
        checkOutput("mis_pulse_end", misaligned_o, 0);
        checkOutput("mis_still_no_req", mem_req_o, 0);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 5'd4);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput("ill_pulse", misaligned_o, 1);
        checkOutput("ill_no_req", mem_req_o, 0);
        cyc();

        // Load into x0: no writeback, previous writeback values held.
        runLoad("lw_x0", 2'b10, 1'b0, 32'h100, 5'd0, 32'h11112222, 32'h100, 4'b1111);
        checkOutput("x0_no_wb", wb_we_o, 0);
        checkOutput("x0_data_hold", wb_data_o, 32'hFFFFBEEF);
        checkOutput("x0_addr_hold", wb_addr_o, 9);

        // Reset while waiting for the response, then a late rvalid.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3);
        cyc();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        checkOutput("abort_in_resp", ctrl_ready_o, 0);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        checkOutput("abort_ready", ctrl_ready_o, 1);
        checkOutput("abort_wb_addr", wb_addr_o, 0);
        checkOutput("abort_wb_data", wb_data_o, 32'h0);
        cyc();
        mem_rvalid_i = 1'b0;
        checkOutput("abort_no_wb", wb_we_o, 0);
        checkOutput("abort_idle", ctrl_ready_o, 1);
        checkOutput("abort_no_req", mem_req_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu.md
JEDRO_1_LSU -- requirements
Module: jedro_1_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data/address width; only 32 is supported.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, SHALL set the destination register index width.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 ctrl_valid_i  in  1  load/store request valid.
REQ-006 ctrl_ready_o  out  1  LSU can accept a request.
REQ-007 ctrl_we_i  in  1  1=store, 0=load.
REQ-008 ctrl_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-009 ctrl_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 ctrl_addr_i  in  32  byte address.
REQ-011 ctrl_wdata_i  in  32  store data, right-aligned.
REQ-012 ctrl_rd_i  in  REG_ADDR_WIDTH  load destination register.
REQ-013 mem_req_o  out  1 / mem_gnt_i  in  1  bus request/grant.
REQ-014 mem_addr_o  out  32  word-aligned address, bits [1:0] = 0.
REQ-015 mem_we_o  out  1 / mem_be_o  out  4 / mem_wdata_o  out  32  write enable, byte enables, write data.
REQ-016 mem_rvalid_i  in  1 / mem_rdata_i  in  32  read response.
REQ-017 wb_addr_o  out  REG_ADDR_WIDTH / wb_data_o  out  32 / wb_we_o  out  1  register file write port C drive.
REQ-018 misaligned_o  out  1  one-cycle pulse on a rejected misaligned/illegal access.

Function
REQ-019 FSM states SHALL be IDLE, REQ, RESP; ctrl_ready_o SHALL equal (state==IDLE).
REQ-020 A request SHALL be accepted in cycle N when ctrl_valid_i and ctrl_ready_o are both 1; all ctrl fields latch at N.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11; SHALL stay IDLE, issue no bus request, no writeback, misaligned_o=1 in N+1 only.
REQ-022 Aligned accept SHALL move to REQ; mem_req_o=1 from N+1, with mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o held stable until the grant cycle.
REQ-023 In REQ with mem_gnt_i=1: store SHALL return to IDLE; load SHALL go to RESP; mem_req_o SHALL be 0 the cycle after grant.
REQ-024 Store lanes: byte be=0001<<addr[1:0], wdata = byte replicated x4; half be=0011<<addr[1:0], wdata = half replicated x2; word be=1111, wdata unchanged.
REQ-025 Loads SHALL drive mem_we_o=0, mem_be_o per REQ-024.
REQ-026 In RESP with mem_rvalid_i=1: data = mem_rdata_i >> (8*addr[1:0]), truncated to size, sign/zero-extended to 32 bits; state SHALL return to IDLE.
REQ-027 wb_we_o SHALL pulse for exactly one cycle, the cycle after rvalid, with wb_addr_o=latched rd and wb_data_o=extracted data; suppressed (0) when rd=0.
REQ-028 mem_rvalid_i SHALL be ignored in IDLE and REQ; mem_gnt_i ignored outside REQ.
REQ-029 Minimum load latency: accept N, grant N+1, rvalid N+2, wb_we_o N+3; store completes with grant at N+1, ready again at N+2.
REQ-030 wb_addr_o/wb_data_o SHALL hold their last values while wb_we_o=0.

Reset
REQ-031 rst_i=1 at a clock edge SHALL force state IDLE and mem_req_o, mem_we_o, wb_we_o, misaligned_o to 0; mem_addr_o, mem_be_o, mem_wdata_o, wb_addr_o, wb_data_o to 0.
REQ-032 Reset in REQ or RESP SHALL abort the transaction; no writeback SHALL follow; a late rvalid after reset SHALL be ignored.
REQ-033 ctrl_ready_o SHALL be 1 the cycle after reset is released.

Verification
REQ-034 Load word addr 0x100, rd=5, gnt N+1, rvalid N+2 rdata 0xDEADBEEF -> wb_we_o=1 at N+3, wb_addr_o=5, wb_data_o=0xDEADBEEF.
REQ-035 Load byte signed addr 0x103, rdata 0x80FF_0000 -> wb_data_o=0xFFFFFF80; same unsigned -> 0x00000080.
REQ-036 Store half addr 0x202 data 0x1234ABCD, gnt held low 3 cycles -> mem_req_o held, mem_addr_o=0x200, mem_be_o=1100, mem_wdata_o=0xABCDABCD stable; no wb_we_o.
REQ-037 Load word addr 0x101 -> misaligned_o pulse at N+1, mem_req_o stays 0, ctrl_ready_o stays 1.
REQ-038 Load rd=0 completes -> wb_we_o stays 0; rst_i asserted in RESP then rvalid -> no wb_we_o, state IDLE.
